// File: rtl/psum_accum_wb.sv
// Write-back sequencer from the corelet OFIFO into psum SRAM: each vector either
// overwrites its row or is accumulated into it (read-modify-write), with saturation and optional ReLU.
module psum_accum_wb #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [addr_w-1:0]      base,
    input  logic [addr_w-1:0]      len,
    input  logic                   acc_en,
    input  logic                   relu_en,
    input  logic                   ofifo_valid,
    input  logic [col*psum_bw-1:0] ofifo_out,
    output logic                   ofifo_rd,
    output logic                   pmem_cen,
    output logic                   pmem_wen,
    output logic [addr_w-1:0]      pmem_a,
    output logic [col*psum_bw-1:0] pmem_d,
    input  logic [col*psum_bw-1:0] pmem_q,
    output logic                   busy,
    output logic                   done
);
    localparam int VW = col * psum_bw;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic signed [psum_bw:0] SUM_MAX = {2'b00, {(psum_bw-1){1'b1}}};
    localparam logic signed [psum_bw:0] SUM_MIN = {2'b11, {(psum_bw-1){1'b0}}};
    localparam logic [addr_w-1:0]       IDX_ONE = {{(addr_w-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [addr_w-1:0] idx_q, idx_d;
    logic [addr_w-1:0] base_q, base_d;
    logic [addr_w-1:0] len_q, len_d;
    logic              acc_q, acc_d;
    logic              relu_q, relu_d;
    logic [VW-1:0]     hold_q, hold_d;

    logic [addr_w-1:0] addr;
    logic [addr_w-1:0] idx_inc;
    logic [VW-1:0]     result;

    function automatic logic signed [psum_bw-1:0] sat_lane(input logic signed [psum_bw:0] s);
        logic signed [psum_bw-1:0] r;
        if (s > SUM_MAX) begin
            r = SUM_MAX[psum_bw-1:0];
        end else if (s < SUM_MIN) begin
            r = SUM_MIN[psum_bw-1:0];
        end else begin
            r = s[psum_bw-1:0];
        end
        return r;
    endfunction

    function automatic logic signed [psum_bw-1:0] relu_lane(input logic signed [psum_bw-1:0] v,
                                                            input logic en);
        logic signed [psum_bw-1:0] r;
        r = (en && v[psum_bw-1]) ? '0 : v;
        return r;
    endfunction

    // Address wraps modulo 2^addr_w by construction of the adder width.
    assign addr    = base_q + idx_q;
    assign idx_inc = idx_q + IDX_ONE;

    // One extra bit of headroom per lane so the sum never overflows before saturation.
    for (genvar i = 0; i < col; i++) begin : g_lane
        logic signed [psum_bw-1:0] h;
        logic signed [psum_bw-1:0] q;
        logic signed [psum_bw:0]   s;
        assign h = hold_q[i*psum_bw +: psum_bw];
        assign q = acc_q ? pmem_q[i*psum_bw +: psum_bw] : '0;
        assign s = $signed({h[psum_bw-1], h}) + $signed({q[psum_bw-1], q});
        assign result[i*psum_bw +: psum_bw] = relu_lane(sat_lane(s), relu_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            acc_q   <= 1'b0;
            relu_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
            relu_q  <= relu_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        base_d   = base_q;
        len_d    = len_q;
        acc_d    = acc_q;
        relu_d   = relu_q;
        hold_d   = hold_q;
        ofifo_rd = 1'b0;
        pmem_cen = 1'b1;
        pmem_wen = 1'b1;
        pmem_a   = '0;
        pmem_d   = '0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base;
                    len_d   = len;
                    acc_d   = acc_en;
                    relu_d  = relu_en;
                    idx_d   = '0;
                    state_d = (len != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                busy = 1'b1;
                // The stored row is read in the pop cycle so pmem_q lines up with WRITE.
                if (ofifo_valid) begin
                    ofifo_rd = 1'b1;
                    hold_d   = ofifo_out;
                    if (acc_q) begin
                        pmem_cen = 1'b0;
                        pmem_a   = addr;
                    end
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                busy     = 1'b1;
                pmem_cen = 1'b0;
                pmem_wen = 1'b0;
                pmem_a   = addr;
                pmem_d   = result;
                idx_d    = idx_inc;
                state_d  = (idx_inc == len_q) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_psum_accum_wb.sv
// Directed bench for psum_accum_wb: OFIFO and psum SRAM models around the DUT,
// one task per scenario with hand-computed expected values.
module tb_psum_accum_wb;
    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int AW  = 11;
    localparam int VW  = COL * BW;

    logic          clk;
    logic          reset, start, acc_en, relu_en;
    logic          ofifo_valid, ofifo_rd, pmem_cen, pmem_wen, busy, done;
    logic [AW-1:0] base, len, pmem_a;
    logic [VW-1:0] ofifo_out, pmem_d, pmem_q;

    psum_accum_wb #(.col(COL), .psum_bw(BW), .addr_w(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .len(len),
        .acc_en(acc_en), .relu_en(relu_en), .ofifo_valid(ofifo_valid),
        .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd), .pmem_cen(pmem_cen),
        .pmem_wen(pmem_wen), .pmem_a(pmem_a), .pmem_d(pmem_d), .pmem_q(pmem_q),
        .busy(busy), .done(done)
    );

    always begin
        clk = 1'b0; #5;
        clk = 1'b1; #5;
    end

    logic          tb_init, stall, pl_en;
    logic [AW-1:0] pl_addr;
    logic [VW-1:0] pl_data;
    logic [VW-1:0] fifo_mem [0:15];
    int            wr_ptr, rd_ptr;
    logic [VW-1:0] mem [0:(1<<AW)-1];

    assign ofifo_valid = (rd_ptr != wr_ptr) && !stall;
    assign ofifo_out   = fifo_mem[rd_ptr[3:0]];

    always @(posedge clk) begin
        if (tb_init) rd_ptr <= 0;
        else if (ofifo_rd === 1'b1 && rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;
    end

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (pmem_cen === 1'b0) begin
            if (pmem_wen === 1'b0) mem[pmem_a] <= pmem_d;
            else pmem_q <= mem[pmem_a];
        end
    end

    int            cyc, wr_n, rd_n, pop_n, done_n, done_cyc, last_rd_cyc;
    logic [AW-1:0] last_rd_a;
    logic [AW-1:0] wr_a [0:63];
    logic [VW-1:0] wr_d [0:63];
    int            wr_cyc [0:63];

    always @(posedge clk) cyc <= tb_init ? 0 : cyc + 1;

    always @(negedge clk) begin
        if (tb_init) begin
            wr_n <= 0; rd_n <= 0; pop_n <= 0; done_n <= 0;
            done_cyc <= 0; last_rd_cyc <= 0; last_rd_a <= '0;
        end else begin
            if (pmem_cen === 1'b0 && pmem_wen === 1'b0) begin
                wr_a[wr_n[5:0]]   <= pmem_a;
                wr_d[wr_n[5:0]]   <= pmem_d;
                wr_cyc[wr_n[5:0]] <= cyc;
                wr_n <= wr_n + 1;
            end
            if (pmem_cen === 1'b0 && pmem_wen === 1'b1) begin
                rd_n <= rd_n + 1;
                last_rd_cyc <= cyc;
                last_rd_a <= pmem_a;
            end
            if (ofifo_rd === 1'b1) pop_n <= pop_n + 1;
            if (done === 1'b1) begin
                done_n <= done_n + 1;
                done_cyc <= cyc;
            end
        end
    end

    int n_vec, n_bad;

    function automatic logic [VW-1:0] mk(input int v);
        logic [VW-1:0] r;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = v[BW-1:0];
        return r;
    endfunction

    function automatic logic [VW-1:0] mk4(input int l0, input int l1, input int l2, input int rest);
        logic [VW-1:0] r;
        r = mk(rest);
        r[0 +: BW]    = l0[BW-1:0];
        r[BW +: BW]   = l1[BW-1:0];
        r[2*BW +: BW] = l2[BW-1:0];
        return r;
    endfunction

    task automatic push(input logic [VW-1:0] v);
        fifo_mem[wr_ptr[3:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic preload(input int a, input logic [VW-1:0] d);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_addr = AW'(a); pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic launch(input int b, input int l, input logic a, input logic r, output int sc);
        @(posedge clk); #1;
        base = AW'(b); len = AW'(l); acc_en = a; relu_en = r; start = 1'b1;
        sc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (done_n != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; tb_init = 1'b1; start = 1'b0; base = '0; len = '0;
        acc_en = 1'b0; relu_en = 1'b0; stall = 1'b0; pl_en = 1'b0;
        pl_addr = '0; pl_data = '0; wr_ptr = 0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (ofifo_rd !== 1'b0) begin n_bad++; $display("FAIL reset_ofifo_rd: got %b want 0", ofifo_rd); end
        n_vec++; if (pmem_cen !== 1'b1) begin n_bad++; $display("FAIL reset_cen: got %b want 1", pmem_cen); end
        n_vec++; if (pmem_wen !== 1'b1) begin n_bad++; $display("FAIL reset_wen: got %b want 1", pmem_wen); end
        n_vec++; if (pmem_a !== '0) begin n_bad++; $display("FAIL reset_a: got %0d want 0", pmem_a); end
        n_vec++; if (pmem_d !== '0) begin n_bad++; $display("FAIL reset_d: got %h want 0", pmem_d); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        tb_init = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_overwrite;
        int sc, w0, r0, p0, d0, j;
        bit ok;
        logic [AW-1:0] ea;
        w0 = wr_n; r0 = rd_n; p0 = pop_n; d0 = done_n;
        push(mk(1)); push(mk(2)); push(mk(3));
        launch(5, 3, 1'b0, 1'b0, sc);
        wait_done(d0, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL overwrite_timeout: got no done want done"); end
        n_vec++; if (done_cyc - sc != 7) begin n_bad++; $display("FAIL overwrite_latency: got %0d want 7", done_cyc - sc); end
        for (int i = 0; i < 3; i++) begin
            j = w0 + i;
            ea = AW'(5 + i);
            n_vec++; if (wr_a[j[5:0]] !== ea) begin n_bad++; $display("FAIL overwrite_addr%0d: got %0d want %0d", i, wr_a[j[5:0]], ea); end
            n_vec++; if (wr_d[j[5:0]] !== mk(i + 1)) begin n_bad++; $display("FAIL overwrite_data%0d: got %h want %h", i, wr_d[j[5:0]], mk(i + 1)); end
        end
        j = w0 + 2;
        n_vec++; if (wr_cyc[j[5:0]] - wr_cyc[w0[5:0]] != 4) begin n_bad++; $display("FAIL overwrite_spacing: got %0d want 4", wr_cyc[j[5:0]] - wr_cyc[w0[5:0]]); end
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (wr_n - w0 != 3) begin n_bad++; $display("FAIL overwrite_nwrites: got %0d want 3", wr_n - w0); end
        n_vec++; if (rd_n - r0 != 0) begin n_bad++; $display("FAIL overwrite_nreads: got %0d want 0", rd_n - r0); end
        n_vec++; if (pop_n - p0 != 3) begin n_bad++; $display("FAIL overwrite_pops: got %0d want 3", pop_n - p0); end
        n_vec++; if (done_n - d0 != 1) begin n_bad++; $display("FAIL overwrite_done_pulses: got %0d want 1", done_n - d0); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL overwrite_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_accumulate;
        int sc, w0, r0, d0;
        bit ok;
        logic [AW-1:0] ea;
        preload(10, mk(100));
        w0 = wr_n; r0 = rd_n; d0 = done_n;
        push(mk(-30));
        launch(10, 1, 1'b1, 1'b0, sc);
        wait_done(d0, ok);
        ea = AW'(10);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL acc_timeout: got no done want done"); end
        n_vec++; if (mem[10] !== mk(70)) begin n_bad++; $display("FAIL acc_data: got %h want %h", mem[10], mk(70)); end
        n_vec++; if (rd_n - r0 != 1) begin n_bad++; $display("FAIL acc_nreads: got %0d want 1", rd_n - r0); end
        n_vec++; if (last_rd_a !== ea) begin n_bad++; $display("FAIL acc_read_addr: got %0d want 10", last_rd_a); end
        n_vec++; if (wr_cyc[w0[5:0]] - last_rd_cyc != 1) begin n_bad++; $display("FAIL acc_read_to_write: got %0d want 1", wr_cyc[w0[5:0]] - last_rd_cyc); end
        n_vec++; if (done_cyc - sc != 3) begin n_bad++; $display("FAIL acc_latency: got %0d want 3", done_cyc - sc); end
    endtask

    task automatic test_saturation;
        int sc, d0;
        bit ok;
        preload(20, mk4(32000, -5, 10, -32768));
        d0 = done_n;
        push(mk4(1000, -7, 20, -1));
        launch(20, 1, 1'b1, 1'b1, sc);
        wait_done(d0, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL sat_relu_timeout: got no done want done"); end
        n_vec++; if (mem[20] !== mk4(32767, 0, 30, 0)) begin n_bad++; $display("FAIL sat_relu_data: got %h want %h", mem[20], mk4(32767, 0, 30, 0)); end
        preload(21, mk4(-32768, -5, 32767, 3));
        d0 = done_n;
        push(mk4(-1, -7, 1, 4));
        launch(21, 1, 1'b1, 1'b0, sc);
        wait_done(d0, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL sat_norelu_timeout: got no done want done"); end
        n_vec++; if (mem[21] !== mk4(-32768, -12, 32767, 7)) begin n_bad++; $display("FAIL sat_norelu_data: got %h want %h", mem[21], mk4(-32768, -12, 32767, 7)); end
    endtask

    task automatic test_stall;
        int sc, w0, p0, d0, j;
        bit ok, seen;
        logic [AW-1:0] ea;
        w0 = wr_n; p0 = pop_n; d0 = done_n;
        push(mk(11)); push(mk(12)); push(mk(13));
        launch(40, 3, 1'b0, 1'b0, sc);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (pmem_cen === 1'b0 && pmem_wen === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        n_vec++; if (!seen) begin n_bad++; $display("FAIL stall_first_write: got none want write"); end
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n_vec++; if (pmem_cen !== 1'b1) begin n_bad++; $display("FAIL stall_cen%0d: got %b want 1", i, pmem_cen); end
            n_vec++; if (ofifo_rd !== 1'b0) begin n_bad++; $display("FAIL stall_rd%0d: got %b want 0", i, ofifo_rd); end
        end
        @(posedge clk); #1;
        stall = 1'b0;
        wait_done(d0, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL stall_timeout: got no done want done"); end
        n_vec++; if (done_cyc - sc != 11) begin n_bad++; $display("FAIL stall_latency: got %0d want 11", done_cyc - sc); end
        for (int i = 0; i < 3; i++) begin
            j = w0 + i;
            ea = AW'(40 + i);
            n_vec++; if (wr_a[j[5:0]] !== ea) begin n_bad++; $display("FAIL stall_addr%0d: got %0d want %0d", i, wr_a[j[5:0]], ea); end
            n_vec++; if (wr_d[j[5:0]] !== mk(11 + i)) begin n_bad++; $display("FAIL stall_data%0d: got %h want %h", i, wr_d[j[5:0]], mk(11 + i)); end
        end
        n_vec++; if (pop_n - p0 != 3) begin n_bad++; $display("FAIL stall_pops: got %0d want 3", pop_n - p0); end
    endtask

    task automatic test_wrap_len0;
        int sc, w0, r0, p0, d0, j;
        bit ok;
        logic [AW-1:0] ea;
        w0 = wr_n; d0 = done_n;
        push(mk(21)); push(mk(22)); push(mk(23)); push(mk(24));
        launch(2046, 4, 1'b0, 1'b0, sc);
        wait_done(d0, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL wrap_timeout: got no done want done"); end
        n_vec++; if (done_cyc - sc != 9) begin n_bad++; $display("FAIL wrap_latency: got %0d want 9", done_cyc - sc); end
        for (int i = 0; i < 4; i++) begin
            j = w0 + i;
            ea = AW'(2046 + i);
            n_vec++; if (wr_a[j[5:0]] !== ea) begin n_bad++; $display("FAIL wrap_addr%0d: got %0d want %0d", i, wr_a[j[5:0]], ea); end
            n_vec++; if (wr_d[j[5:0]] !== mk(21 + i)) begin n_bad++; $display("FAIL wrap_data%0d: got %h want %h", i, wr_d[j[5:0]], mk(21 + i)); end
        end
        w0 = wr_n; r0 = rd_n; p0 = pop_n; d0 = done_n;
        push(mk(99));
        launch(300, 0, 1'b1, 1'b0, sc);
        wait_done(d0, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL len0_timeout: got no done want done"); end
        n_vec++; if (done_cyc - sc != 1) begin n_bad++; $display("FAIL len0_latency: got %0d want 1", done_cyc - sc); end
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (wr_n - w0 != 0) begin n_bad++; $display("FAIL len0_writes: got %0d want 0", wr_n - w0); end
        n_vec++; if (rd_n - r0 != 0) begin n_bad++; $display("FAIL len0_reads: got %0d want 0", rd_n - r0); end
        n_vec++; if (pop_n - p0 != 0) begin n_bad++; $display("FAIL len0_pops: got %0d want 0", pop_n - p0); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL len0_busy: got %b want 0", busy); end
        wr_ptr = rd_ptr;
    endtask

    task automatic test_start_ignored;
        int sc, w0, p0, d0, j;
        bit ok;
        logic [AW-1:0] ea;
        w0 = wr_n; p0 = pop_n; d0 = done_n;
        push(mk(31)); push(mk(32));
        launch(60, 2, 1'b0, 1'b0, sc);
        base = AW'(500); len = AW'(1); start = 1'b1;
        wait_done(d0, ok);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (!ok) begin n_bad++; $display("FAIL ignore_timeout: got no done want done"); end
        n_vec++; if (done_n - d0 != 1) begin n_bad++; $display("FAIL ignore_done_pulses: got %0d want 1", done_n - d0); end
        n_vec++; if (wr_n - w0 != 2) begin n_bad++; $display("FAIL ignore_nwrites: got %0d want 2", wr_n - w0); end
        for (int i = 0; i < 2; i++) begin
            j = w0 + i;
            ea = AW'(60 + i);
            n_vec++; if (wr_a[j[5:0]] !== ea) begin n_bad++; $display("FAIL ignore_addr%0d: got %0d want %0d", i, wr_a[j[5:0]], ea); end
        end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_busy: got %b want 0", busy); end
        n_vec++; if (pop_n - p0 != 2) begin n_bad++; $display("FAIL ignore_pops: got %0d want 2", pop_n - p0); end
    endtask

    task automatic test_reset_midpass;
        int sc, p0, d0;
        bit ok, seen;
        for (int i = 0; i < 8; i++) preload(100 + i, mk(7777));
        p0 = pop_n;
        for (int i = 0; i < 8; i++) push(mk(50 + i));
        launch(100, 8, 1'b0, 1'b0, sc);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (pmem_cen === 1'b0 && pmem_wen === 1'b0 && pop_n - p0 == 4) begin
                seen = 1'b1;
                break;
            end
        end
        n_vec++; if (!seen) begin n_bad++; $display("FAIL midrst_reach_write: got none want 4th write"); end
        reset = 1'b1;
        #1;
        n_vec++; if (ofifo_rd !== 1'b0) begin n_bad++; $display("FAIL midrst_ofifo_rd: got %b want 0", ofifo_rd); end
        n_vec++; if (pmem_cen !== 1'b1) begin n_bad++; $display("FAIL midrst_cen: got %b want 1", pmem_cen); end
        n_vec++; if (pmem_wen !== 1'b1) begin n_bad++; $display("FAIL midrst_wen: got %b want 1", pmem_wen); end
        n_vec++; if (pmem_a !== '0) begin n_bad++; $display("FAIL midrst_a: got %0d want 0", pmem_a); end
        n_vec++; if (pmem_d !== '0) begin n_bad++; $display("FAIL midrst_d: got %h want 0", pmem_d); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b want 0", done); end
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (pop_n - p0 != 4) begin n_bad++; $display("FAIL midrst_pops: got %0d want 4", pop_n - p0); end
        n_vec++; if (mem[103] !== mk(7777)) begin n_bad++; $display("FAIL midrst_partial_write: got %h want %h", mem[103], mk(7777)); end
        n_vec++; if (mem[102] !== mk(52)) begin n_bad++; $display("FAIL midrst_prior_write: got %h want %h", mem[102], mk(52)); end
        reset = 1'b0;
        @(negedge clk); #1;
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_idle_after: got %b want 0", busy); end
        wr_ptr = rd_ptr;
        d0 = done_n;
        push(mk(9));
        launch(200, 1, 1'b0, 1'b0, sc);
        wait_done(d0, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL midrst_restart_timeout: got no done want done"); end
        n_vec++; if (done_cyc - sc != 3) begin n_bad++; $display("FAIL midrst_restart_latency: got %0d want 3", done_cyc - sc); end
        n_vec++; if (mem[200] !== mk(9)) begin n_bad++; $display("FAIL midrst_restart_data: got %h want %h", mem[200], mk(9)); end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset;
        test_overwrite;
        test_accumulate;
        test_saturation;
        test_stall;
        test_wrap_len0;
        test_start_ignored;
        test_reset_midpass;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end
endmodule
